expr_cov_sequencer: RTL and testbench



---
 rtl/expr_cov_sequencer_pkg.sv | 21 ++
 rtl/expr_cov_sequencer_if.sv | 29 ++
 rtl/expr_cov_sequencer_sat.sv | 33 +++
 rtl/expr_cov_sequencer.sv | 178 +++++++++++++++++
 tb/tb_expr_cov_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/expr_cov_sequencer_pkg.sv
// Shared types for the OR-expression coverage sequencer.
// Row index, state encoding and the golden row result.
package expr_cov_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } expr_cov_state_e;

    localparam int NUM_ROWS = 4;

    typedef logic [1:0] row_idx_t;

    function automatic logic row_expected(row_idx_t r);
        return r[1] | r[0];
    endfunction

endpackage

// File: rtl/expr_cov_sequencer_if.sv
// Control/datapath bundle between test control and the sequencer.
// master = test-control side, slave = sequencer.
interface expr_cov_sequencer_if #(
    parameter int CNT_W = 8
);
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  drv_a;
    logic                  drv_b;
    logic                  drv_valid;
    logic                  dut_y;
    logic [4*CNT_W-1:0]    row_hit;
    logic [CNT_W-1:0]      mismatch_cnt;
    logic                  err;

    modport master (
        output start, abort, dut_y,
        input  busy, done, drv_a, drv_b, drv_valid,
        input  row_hit, mismatch_cnt, err
    );

    modport slave (
        input  start, abort, dut_y,
        output busy, done, drv_a, drv_b, drv_valid,
        output row_hit, mismatch_cnt, err
    );
endinterface

// File: rtl/expr_cov_sequencer_sat.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment in the same cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/expr_cov_sequencer.sv
// Walks {a,b} through all OR truth-table rows and counts hits per row.
// Define EXPR_COV_CHECK_EN to build the result comparator and mismatch counter.
module expr_cov_sequencer
    import expr_cov_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int REPEAT        = 1,
    parameter int CNT_W         = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    expr_cov_sequencer_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST =
        SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [7:0] PASS_LAST = 8'(REPEAT - 1);

    expr_cov_state_e state_q, state_d;
    row_idx_t        r_q, r_d;
    logic [7:0]      p_q, p_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            drv_a_q, drv_a_d;
    logic            drv_b_q, drv_b_d;
    logic            drv_valid_q, drv_valid_d;
    logic            clr;
    logic            sample;
    row_idx_t        r_nxt;

    assign r_nxt = r_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        p_d         = p_q;
        settle_d    = settle_q;
        drv_a_d     = drv_a_q;
        drv_b_d     = drv_b_q;
        drv_valid_d = drv_valid_q;
        clr         = 1'b0;
        sample      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    clr         = 1'b1;
                    r_d         = '0;
                    p_d         = '0;
                    drv_a_d     = 1'b0;
                    drv_b_d     = 1'b0;
                    drv_valid_d = 1'b1;
                    state_d     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = '0;
                state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                sample = 1'b1;
                if (r_q != 2'd3) begin
                    r_d                = r_nxt;
                    {drv_a_d, drv_b_d} = r_nxt;
                    state_d            = S_DRIVE;
                end else if (p_q != PASS_LAST) begin
                    r_d                = '0;
                    p_d                = p_q + 8'd1;
                    {drv_a_d, drv_b_d} = 2'b00;
                    state_d            = S_DRIVE;
                end else begin
                    {drv_a_d, drv_b_d} = 2'b00;
                    drv_valid_d        = 1'b0;
                    state_d            = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // An aborted sample is not counted; earlier rows keep their counts.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            drv_a_d     = 1'b0;
            drv_b_d     = 1'b0;
            drv_valid_d = 1'b0;
            sample      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            p_q         <= '0;
            settle_q    <= '0;
            drv_a_q     <= 1'b0;
            drv_b_q     <= 1'b0;
            drv_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            p_q         <= p_d;
            settle_q    <= settle_d;
            drv_a_q     <= drv_a_d;
            drv_b_q     <= drv_b_d;
            drv_valid_q <= drv_valid_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.drv_a     = drv_a_q;
    assign bus.drv_b     = drv_b_q;
    assign bus.drv_valid = drv_valid_q;

    logic [NUM_ROWS*CNT_W-1:0] row_hit;

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        sat_counter #(.W(CNT_W)) u_hit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (sample && (r_q == row_idx_t'(i))),
            .q     (row_hit[i*CNT_W +: CNT_W])
        );
    end

    assign bus.row_hit = row_hit;

`ifdef EXPR_COV_CHECK_EN
    logic miss;
    logic err_q, err_d;

    assign miss = sample && (bus.dut_y != row_expected(r_q));

    sat_counter #(.W(CNT_W)) u_miss (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (miss),
        .q     (bus.mismatch_cnt)
    );

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = 1'b0;
        end else if (miss) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_dut_y;

    assign unused_dut_y     = bus.dut_y;
    assign bus.mismatch_cnt = '0;
    assign bus.err          = 1'b0;
`endif
endmodule

// File: tb/tb_expr_cov_sequencer.sv
// Directed bench: three sequencer configurations driven from one control stream.
// Per-cycle tables for the default run plus hand sequences for abort/reset.
module tb_expr_cov_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic y_stuck;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    expr_cov_sequencer_if #(.CNT_W(8)) if1 ();
    expr_cov_sequencer_if #(.CNT_W(8)) if2 ();
    expr_cov_sequencer_if #(.CNT_W(2)) if3 ();

    assign if1.start = start;
    assign if2.start = start;
    assign if3.start = start;
    assign if1.abort = abort;
    assign if2.abort = abort;
    assign if3.abort = abort;
    assign if1.dut_y = y_stuck ? 1'b0 : (if1.drv_a | if1.drv_b);
    assign if2.dut_y = if2.drv_a | if2.drv_b;
    assign if3.dut_y = if3.drv_a | if3.drv_b;

    expr_cov_sequencer u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    expr_cov_sequencer #(.SETTLE_CYCLES(0), .REPEAT(3)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    expr_cov_sequencer #(.CNT_W(2), .REPEAT(5)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    typedef struct {
        int   cyc;
        logic a;
        logic b;
        logic v;
        logic bsy;
        logic dn;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic logic [4:0] obs1();
        return {if1.drv_a, if1.drv_b, if1.drv_valid, if1.busy, if1.done};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dn_seen;
        tbl[0]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{8,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        y_stuck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", obs1(), 5'b0);
        chk("reset_cnt", {if1.row_hit, if1.mismatch_cnt, if1.err}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Run 1: all three configurations with a correct datapath.
        pulse_start();
        k = 0;
        for (int c = 1; c <= 82; c++) begin
            @(negedge clk);
            if (k < 12 && tbl[k].cyc == c) begin
                chk($sformatf("seq1_c%0d", c), obs1(),
                    {tbl[k].a, tbl[k].b, tbl[k].v, tbl[k].bsy, tbl[k].dn});
                k++;
            end
            if (c == 1 || c == 24 || c == 25 || c == 26) begin
                chk($sformatf("seq2_c%0d", c),
                    {if2.drv_valid, if2.done, if2.busy},
                    {c <= 24, c == 25, c <= 25});
            end
            if (c == 80 || c == 81 || c == 82) begin
                chk($sformatf("done3_c%0d", c), if3.done, c == 81);
            end
        end
        chk("tbl_applied", k, 12);
        chk("hit1", if1.row_hit, {4{8'd1}});
        chk("err1", {if1.mismatch_cnt, if1.err}, '0);
        chk("hit2", if2.row_hit, {4{8'd3}});
        chk("hit3_sat", if3.row_hit, {4{2'd3}});

        // Run 2: datapath output stuck at 0.
        y_stuck = 1'b1;
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
        end
        chk("stuck_idle", if1.busy, 1'b0);
        chk("stuck_hits", if1.row_hit, {4{8'd1}});
`ifdef EXPR_COV_CHECK_EN
        chk("stuck_miss", {if1.mismatch_cnt, if1.err}, {8'd3, 1'b1});
`else
        chk("stuck_miss", {if1.mismatch_cnt, if1.err}, {8'd0, 1'b0});
`endif
        pulse_start();
        @(negedge clk);
        chk("restart_clr", {if1.row_hit, if1.mismatch_cnt, if1.err}, '0);
        chk("restart_busy", if1.busy, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_all", {if1.busy, if2.busy, if3.busy}, 3'b000);
        y_stuck = 1'b0;

        // Abort in cycle 6 of a default run.
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
        end
        chk("pre_abort", obs1(), 5'b01110);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_c7", obs1(), 5'b0);
        chk("abort_hits", if1.row_hit, {8'd0, 8'd0, 8'd0, 8'd1});
        dn_seen = 0;
        for (int c = 8; c <= 30; c++) begin
            @(negedge clk);
            if (if1.done || if1.busy) dn_seen++;
        end
        chk("abort_no_done", dn_seen, 0);

        // start together with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", obs1(), 5'b0);
        chk("start_abort_hits", if1.row_hit, {8'd0, 8'd0, 8'd0, 8'd1});

        // Reset low during cycle 5 of a run.
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_c5", {obs1(), if1.row_hit},
            {5'b01110, 8'd0, 8'd0, 8'd0, 8'd1});
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_reset",
            {obs1(), if1.row_hit, if1.mismatch_cnt, if1.err}, '0);
        @(negedge clk);
        chk("post_reset_idle", if1.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
